// File: rtl/midi_pkg.sv
// ============================================================================
// midi_pkg: event encoding and per-voice state shared by the voice allocator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package midi_pkg;

    typedef enum logic [1:0] {
        EVT_NOTE_ON  = 2'd0,
        EVT_NOTE_OFF = 2'd1,
        EVT_SUSTAIN  = 2'd2,
        EVT_ALL_OFF  = 2'd3
    } evt_t;

    localparam logic [6:0] SUSTAIN_THRESHOLD = 7'd64;

    // Stored field widths; the allocator's RATE_WIDTH/AGE_WIDTH track these.
    localparam int VOICE_RATE_WIDTH = 24;
    localparam int VOICE_AGE_WIDTH  = 8;

    typedef struct packed {
        logic                        on;
        logic                        held;
        logic [3:0]                  channel;
        logic [6:0]                  note;
        logic [6:0]                  velocity;
        logic [VOICE_RATE_WIDTH-1:0] rate;
        logic [VOICE_AGE_WIDTH-1:0]  age;
    } voice_t;

endpackage

`default_nettype wire

// File: rtl/voice_mixer.sv
// ============================================================================
// voice_mixer: registered sum of the sounding voices' samples plus voice count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module voice_mixer #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int MIX_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_VOICES),
    parameter int CNT_WIDTH    = $clog2(NUM_VOICES + 1)
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic [NUM_VOICES-1:0]                  is_on_i,
    input  logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0] samples_i,
    output logic [MIX_WIDTH-1:0]                   stream_o,
    output logic [CNT_WIDTH-1:0]                   count_o
);

    logic [MIX_WIDTH-1:0] sum_d, sum_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        sum_d = '0;
        cnt_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (is_on_i[i]) begin
                sum_d = sum_d + MIX_WIDTH'(samples_i[i]);
                cnt_d = cnt_d + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign stream_o = sum_q;
    assign count_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/midi_voice_allocator.sv
// ============================================================================
// midi_voice_allocator: scans voices one per cycle to place/steal/release notes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int RATE_WIDTH   = VOICE_RATE_WIDTH,
    parameter int AGE_WIDTH    = VOICE_AGE_WIDTH,
    parameter int MIX_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_VOICES)
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    valid_in,
    output logic                                    ready_out,
    input  midi_pkg::evt_t                          evt_type_in,
    input  logic [3:0]                              channel_in,
    input  logic [6:0]                              note_in,
    input  logic [6:0]                              velocity_in,
    input  logic [RATE_WIDTH-1:0]                   rate_in,
    output logic [NUM_VOICES-1:0][RATE_WIDTH-1:0]   playback_rate,
    output logic [NUM_VOICES-1:0][6:0]              voice_velocity,
    output logic [NUM_VOICES-1:0]                   is_on,
    input  logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0] out_samples,
    output logic [MIX_WIDTH-1:0]                    stream_out,
    output logic [$clog2(NUM_VOICES+1)-1:0]         active_count,
    output logic                                    has_updated
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [VOICE_AGE_WIDTH-1:0] AGE_MAX = VOICE_AGE_WIDTH'({AGE_WIDTH{1'b1}});

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_COMMIT = 2'd2} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    evt_t                        evt_q, evt_d;
    logic [3:0]                  chan_q, chan_d;
    logic [6:0]                  note_q, note_d;
    logic [6:0]                  vel_q, vel_d;
    logic [VOICE_RATE_WIDTH-1:0] rate_q, rate_d;
    logic                        sustain_q, sustain_d;
    logic                        upd_q, upd_d;
    voice_t                      voices_q [NUM_VOICES];
    voice_t                      voices_d [NUM_VOICES];

    logic                        match_vld_q, match_vld_d, free_vld_q, free_vld_d;
    logic                        held_vld_q, held_vld_d, old_vld_q, old_vld_d;
    logic [IDX_W-1:0]            match_idx_q, match_idx_d, free_idx_q, free_idx_d;
    logic [IDX_W-1:0]            held_idx_q, held_idx_d, old_idx_q, old_idx_d;
    logic [VOICE_AGE_WIDTH-1:0]  held_age_q, held_age_d, old_age_q, old_age_d;

    voice_t                      cur;
    logic [IDX_W-1:0]            sel;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        evt_d       = evt_q;
        chan_d      = chan_q;
        note_d      = note_q;
        vel_d       = vel_q;
        rate_d      = rate_q;
        sustain_d   = sustain_q;
        upd_d       = 1'b0;
        voices_d    = voices_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        held_vld_d  = held_vld_q;
        held_idx_d  = held_idx_q;
        held_age_d  = held_age_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        cur         = voices_q[idx_q];
        sel         = '0;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    evt_d = (evt_type_in == EVT_NOTE_ON && velocity_in == 7'd0) ? EVT_NOTE_OFF
                                                                                 : evt_type_in;
                    chan_d      = channel_in;
                    note_d      = note_in;
                    vel_d       = velocity_in;
                    rate_d      = VOICE_RATE_WIDTH'(rate_in);
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    held_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    idx_d       = '0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur.on && cur.channel == chan_q && cur.note == note_q && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!cur.on && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                // Strict '>' keeps the lowest index on age ties.
                if (cur.on && cur.held && (!held_vld_q || cur.age > held_age_q)) begin
                    held_vld_d = 1'b1;
                    held_idx_d = idx_q;
                    held_age_d = cur.age;
                end
                if (cur.on && (!old_vld_q || cur.age > old_age_q)) begin
                    old_vld_d = 1'b1;
                    old_idx_d = idx_q;
                    old_age_d = cur.age;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                upd_d   = 1'b1;
                state_d = S_IDLE;
                sel = match_vld_q ? match_idx_q :
                      free_vld_q  ? free_idx_q  :
                      held_vld_q  ? held_idx_q  : old_idx_q;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    case (evt_q)
                        EVT_NOTE_ON: begin
                            if (IDX_W'(i) == sel) begin
                                voices_d[i].on       = 1'b1;
                                voices_d[i].held     = 1'b0;
                                voices_d[i].age      = '0;
                                voices_d[i].channel  = chan_q;
                                voices_d[i].note     = note_q;
                                voices_d[i].velocity = vel_q;
                                voices_d[i].rate     = rate_q;
                            end else if (voices_q[i].on && voices_q[i].age != AGE_MAX) begin
                                voices_d[i].age = voices_q[i].age + VOICE_AGE_WIDTH'(1);
                            end
                        end
                        EVT_NOTE_OFF: begin
                            if (voices_q[i].on && voices_q[i].channel == chan_q &&
                                voices_q[i].note == note_q) begin
                                if (sustain_q) begin
                                    voices_d[i].held = 1'b1;
                                end else begin
                                    voices_d[i].on   = 1'b0;
                                    voices_d[i].held = 1'b0;
                                    voices_d[i].rate = '0;
                                end
                            end
                        end
                        EVT_SUSTAIN: begin
                            if (vel_q < SUSTAIN_THRESHOLD && voices_q[i].held) begin
                                voices_d[i].on   = 1'b0;
                                voices_d[i].held = 1'b0;
                                voices_d[i].rate = '0;
                            end
                        end
                        default: begin
                            if (voices_q[i].channel == chan_q) begin
                                voices_d[i].on   = 1'b0;
                                voices_d[i].held = 1'b0;
                                voices_d[i].rate = '0;
                            end
                        end
                    endcase
                end
                if (evt_q == EVT_SUSTAIN) begin
                    sustain_d = (vel_q >= SUSTAIN_THRESHOLD);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            evt_q       <= EVT_NOTE_ON;
            chan_q      <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            rate_q      <= '0;
            sustain_q   <= 1'b0;
            upd_q       <= 1'b0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            held_vld_q  <= 1'b0;
            held_idx_q  <= '0;
            held_age_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            evt_q       <= evt_d;
            chan_q      <= chan_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            rate_q      <= rate_d;
            sustain_q   <= sustain_d;
            upd_q       <= upd_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            held_vld_q  <= held_vld_d;
            held_idx_q  <= held_idx_d;
            held_age_q  <= held_age_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices_q[i] <= voices_d[i];
            end
        end
    end

    assign ready_out   = (state_q == S_IDLE);
    assign has_updated = upd_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_out
        assign playback_rate[g]  = RATE_WIDTH'(voices_q[g].rate);
        assign voice_velocity[g] = voices_q[g].velocity;
        assign is_on[g]          = voices_q[g].on;
    end

    voice_mixer #(
        .NUM_VOICES   (NUM_VOICES),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .MIX_WIDTH    (MIX_WIDTH),
        .CNT_WIDTH    ($clog2(NUM_VOICES + 1))
    ) u_mixer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .is_on_i   (is_on),
        .samples_i (out_samples),
        .stream_o  (stream_out),
        .count_o   (active_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
// ============================================================================
// tb_midi_voice_allocator: directed vectors with hand-computed expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_midi_voice_allocator;
    import midi_pkg::*;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              valid_in;
    logic              ready_out;
    evt_t              evt_type_in;
    logic [3:0]        channel_in;
    logic [6:0]        note_in;
    logic [6:0]        velocity_in;
    logic [23:0]       rate_in;
    logic [7:0][23:0]  playback_rate;
    logic [7:0][6:0]   voice_velocity;
    logic [7:0]        is_on;
    logic [7:0][15:0]  out_samples;
    logic [18:0]       stream_out;
    logic [3:0]        active_count;
    logic              has_updated;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    midi_voice_allocator dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .evt_type_in    (evt_type_in),
        .channel_in     (channel_in),
        .note_in        (note_in),
        .velocity_in    (velocity_in),
        .rate_in        (rate_in),
        .playback_rate  (playback_rate),
        .voice_velocity (voice_velocity),
        .is_on          (is_on),
        .out_samples    (out_samples),
        .stream_out     (stream_out),
        .active_count   (active_count),
        .has_updated    (has_updated)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input evt_t t, input logic [3:0] ch, input logic [6:0] n,
                        input logic [6:0] v, input logic [23:0] r);
        int guard;
        int cyc;
        guard = 0;
        while (!ready_out && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        @(negedge clk_in);
        evt_type_in = t;
        channel_in  = ch;
        note_in     = n;
        velocity_in = v;
        rate_in     = r;
        valid_in    = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        check("ready_busy", 32'(ready_out), 32'd0);
        cyc = 0;
        while (!has_updated && cyc < 30) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'd9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in      = 1'b0;
        valid_in    = 1'b0;
        evt_type_in = EVT_NOTE_ON;
        channel_in  = '0;
        note_in     = '0;
        velocity_in = '0;
        rate_in     = '0;
        for (int k = 0; k < 8; k++) out_samples[k] = 16'(100 * (k + 1));

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_is_on", 32'(is_on), 32'd0);
        check("rst_stream", 32'(stream_out), 32'd0);
        check("rst_active", 32'(active_count), 32'd0);
        check("rst_upd", 32'(has_updated), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // First note lands in voice 0
        send(EVT_NOTE_ON, 4'd0, 7'd60, 7'd100, 24'd1000);
        check("on1_is_on", 32'(is_on), 32'h01);
        check("on1_rate0", 32'(playback_rate[0]), 32'd1000);
        check("on1_vel0", 32'(voice_velocity[0]), 32'd100);
        settle();
        check("on1_stream", 32'(stream_out), 32'd100);
        check("on1_active", 32'(active_count), 32'd1);

        // Same note again retriggers voice 0
        send(EVT_NOTE_ON, 4'd0, 7'd60, 7'd50, 24'd2000);
        check("retrig_is_on", 32'(is_on), 32'h01);
        check("retrig_rate0", 32'(playback_rate[0]), 32'd2000);
        check("retrig_vel0", 32'(voice_velocity[0]), 32'd50);
        settle();
        check("retrig_active", 32'(active_count), 32'd1);

        // Fill voices 1..7 with notes 61..67
        for (int n = 61; n <= 67; n++) send(EVT_NOTE_ON, 4'd0, 7'(n), 7'(n - 50), 24'(1000 + n));
        check("full_is_on", 32'(is_on), 32'hFF);
        check("full_rate7", 32'(playback_rate[7]), 32'd1067);
        settle();
        check("full_stream", 32'(stream_out), 32'd3600);
        check("full_active", 32'(active_count), 32'd8);

        // Steal oldest (voice 0, age 7)
        send(EVT_NOTE_ON, 4'd0, 7'd70, 7'd90, 24'd7000);
        check("steal_rate0", 32'(playback_rate[0]), 32'd7000);
        check("steal_vel0", 32'(voice_velocity[0]), 32'd90);
        check("steal_rate1", 32'(playback_rate[1]), 32'd1061);
        check("steal_is_on", 32'(is_on), 32'hFF);

        // Held voice 7 (age 1) is stolen ahead of un-held voice 1 (age 7)
        send(EVT_SUSTAIN, 4'd0, 7'd0, 7'd127, 24'd0);
        send(EVT_NOTE_OFF, 4'd0, 7'd67, 7'd0, 24'd0);
        check("hold_is_on", 32'(is_on), 32'hFF);
        check("hold_rate7", 32'(playback_rate[7]), 32'd1067);
        send(EVT_NOTE_ON, 4'd0, 7'd71, 7'd33, 24'd7100);
        check("stealheld_rate7", 32'(playback_rate[7]), 32'd7100);
        check("stealheld_vel7", 32'(voice_velocity[7]), 32'd33);
        check("stealheld_rate1", 32'(playback_rate[1]), 32'd1061);

        // Voice 6 held, then sustain release turns it off
        send(EVT_NOTE_OFF, 4'd0, 7'd66, 7'd0, 24'd0);
        check("hold6_is_on", 32'(is_on), 32'hFF);
        send(EVT_SUSTAIN, 4'd0, 7'd0, 7'd0, 24'd0);
        check("release_is_on", 32'(is_on), 32'hBF);
        check("release_rate6", 32'(playback_rate[6]), 32'd0);
        check("release_rate7", 32'(playback_rate[7]), 32'd7100);

        // Velocity 0 note-on acts as note-off
        send(EVT_NOTE_ON, 4'd0, 7'd62, 7'd0, 24'd5555);
        check("vel0_is_on", 32'(is_on), 32'hBB);
        check("vel0_rate2", 32'(playback_rate[2]), 32'd0);

        // Lowest free voice is 2
        send(EVT_NOTE_ON, 4'd1, 7'd40, 7'd10, 24'd500);
        check("free_is_on", 32'(is_on), 32'hBF);
        check("free_rate2", 32'(playback_rate[2]), 32'd500);
        check("free_vel2", 32'(voice_velocity[2]), 32'd10);

        // All-off on channel 1 leaves channel 0 voices
        send(EVT_ALL_OFF, 4'd1, 7'd0, 7'd0, 24'd0);
        check("alloff_is_on", 32'(is_on), 32'hBB);
        check("alloff_rate2", 32'(playback_rate[2]), 32'd0);
        settle();
        check("alloff_stream", 32'(stream_out), 32'd2600);
        check("alloff_active", 32'(active_count), 32'd6);

        // Unmatched note-off still completes with no state change
        send(EVT_NOTE_OFF, 4'd0, 7'd99, 7'd0, 24'd0);
        check("nomatch_is_on", 32'(is_on), 32'hBB);

        // Reset asserted mid-scan
        @(negedge clk_in);
        evt_type_in = EVT_NOTE_ON;
        channel_in  = 4'd0;
        note_in     = 7'd80;
        velocity_in = 7'd1;
        rate_in     = 24'd1;
        valid_in    = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("midrst_is_on", 32'(is_on), 32'd0);
        check("midrst_ready", 32'(ready_out), 32'd1);
        check("midrst_stream", 32'(stream_out), 32'd0);
        check("midrst_active", 32'(active_count), 32'd0);
        check("midrst_upd", 32'(has_updated), 32'd0);
        check("midrst_rate0", 32'(playback_rate[0]), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (12) @(posedge clk_in);
        #1;
        check("abandon_is_on", 32'(is_on), 32'd0);
        check("abandon_upd", 32'(has_updated), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
